dbus_io_bridge: RTL and testbench
=================================

Name: dbus_io_bridge

Overview:
- Data-bus bridge between the multicycle RISC-V processor data port and its two targets: data memory and the I/O sub-system.
- Decodes each processor access into memory, I/O or unmapped, and gates the write strobes to the matching target.
- Registers I/O read data and returns the selected read word on dReadData one cycle after MemRead.
- Latches a sticky error record for illegal accesses.

Parameters:
- DATA_START_ADDRESS, 32'h00002000, first byte of data-memory region.
- DATA_END_ADDRESS, 32'h00003FFF, last byte of data-memory region.
- IO_BASE, 32'h00007F00, base of I/O region.
- IO_MASK, 32'hFFFFFF00, address bits compared against IO_BASE.

Ports:
- clk  input  1  processor clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- dAddress  input  32  processor data address.
- MemRead  input  1  processor read strobe, one cycle per access.
- MemWrite  input  1  processor write strobe, one cycle per access.
- dWriteData  input  32  processor write data.
- dReadData  output  32  read data returned to processor.
- mem_write  output  1  gated write strobe to data memory.
- mem_read_data  input  32  data-memory read word, valid the cycle after address.
- io_address  output  32  address to I/O sub-system, equal to dAddress.
- io_memory_read  output  1  gated read strobe to I/O.
- io_memory_write  output  1  gated write strobe to I/O.
- io_write_data  output  32  equal to dWriteData.
- io_read_data  input  32  I/O read word.
- valid_io_read  input  1  I/O asserts when io_read_data is valid for the addressed register.
- err_clr  input  1  synchronous clear of error record.
- bus_error  output  1  sticky error flag.
- err_code  output  2  error code: 1 = unmapped, 2 = misaligned, 3 = read+write together.
- err_addr  output  32  address of first error.
- io_access_count  output  16  count of accepted I/O accesses, reads plus writes.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; dReadData, err_addr, io_access_count = 0; bus_error = 0; err_code = 0. All gated strobes are 0 while rst is low.
- Decode (combinational from dAddress):
  - mem_hit = DATA_START_ADDRESS <= dAddress <= DATA_END_ADDRESS.
  - io_hit = (dAddress & IO_MASK) == IO_BASE.
  - mem_hit takes priority if both match.
  - misaligned = dAddress[1:0] != 0.
- Legal access: exactly one of MemRead/MemWrite is high, the address hits a region, and it is aligned.
- Strobes (combinational, same cycle as processor strobe):
  - mem_write = MemWrite & legal & mem_hit.
  - io_memory_write = MemWrite & legal & io_hit.
  - io_memory_read = MemRead & legal & io_hit.
  - Illegal accesses produce no strobe to either target.
- State machine: IDLE, RD_MEM, RD_IO, RD_ERR.
  - From IDLE on MemRead: legal mem -> RD_MEM; legal io -> RD_IO; otherwise -> RD_ERR.
  - In RD_IO, capture io_read_data into io_q at the MemRead edge if valid_io_read is high, else io_q = 0.
  - RD_MEM: dReadData <= mem_read_data at the end of the cycle.
  - RD_IO: dReadData <= io_q.
  - RD_ERR: dReadData <= 0.
  - All three read states return to IDLE after one cycle.
  - Net latency: dReadData valid on the second rising edge after MemRead was sampled.
  - MemRead asserted in a RD_* state is accepted and decoded the same way (back-to-back reads).
- dReadData holds its last value until the next read completes; writes never change it.
- Errors:
  - The first illegal access while bus_error = 0 sets bus_error and latches err_code and err_addr = dAddress.
  - Later errors do not overwrite the record.
  - Code priority: 3 over 2 over 1.
  - err_clr clears bus_error, err_code and err_addr next cycle.
  - If err_clr coincides with a new error, the new error is recorded.
- io_access_count increments on each cycle where io_memory_read or io_memory_write is high, and wraps FFFF -> 0000.
- Reset mid-read: state forced to IDLE and dReadData = 0; the pending read is discarded.

Test Plan:
- Reset, then MemRead at 32'h00002004, with mem_read_data = 32'hDEADBEEF one cycle later -> mem_write = 0; dReadData = 32'hDEADBEEF two edges after MemRead; bus_error = 0.
- MemWrite at 32'h00007F08, data 32'h0000A5A5 -> io_memory_write = 1 the same cycle; mem_write = 0; io_write_data = 32'h0000A5A5; io_access_count = 1.
- MemRead at 32'h00007F00, valid_io_read = 1, io_read_data = 32'h00001234 -> io_memory_read = 1; dReadData = 32'h00001234 after latency; count increments.
- MemWrite at 32'h00005000, then MemRead at 32'h00002002 -> no strobes; bus_error = 1, err_code = 1, err_addr = 32'h00005000. The second error does not overwrite; dReadData = 0. Pulse err_clr -> all cleared.
- MemRead and MemWrite together at 32'h00002000 -> no strobes; err_code = 3.
- Preload io_access_count to FFFF via 65535 I/O writes, then one more -> count = 0000. Assert rst low during RD_IO -> dReadData = 0, state IDLE immediately.

Source files
------------

// File: rtl/dbus_io_bridge_if.sv
// Processor data-port bundle between the multicycle core and the bus bridge.
// The bridge only drives dReadData back to the core.
interface dbus_io_bridge_if;
  logic [31:0] dAddress;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;

  modport master (
    output dAddress,
    output MemRead,
    output MemWrite,
    output dWriteData,
    input  dReadData
  );

  modport slave (
    input  dAddress,
    input  MemRead,
    input  MemWrite,
    input  dWriteData,
    output dReadData
  );
endinterface

// File: rtl/dbus_io_bridge.sv
// Routes processor data accesses to data memory or I/O, returns read data two
// edges after MemRead, and keeps a sticky record of the first illegal access.
module dbus_io_bridge #(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00002000,
  parameter logic [31:0] DATA_END_ADDRESS   = 32'h00003FFF,
  parameter logic [31:0] IO_BASE            = 32'h00007F00,
  parameter logic [31:0] IO_MASK            = 32'hFFFFFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  dbus_io_bridge_if.slave       bus,
  output logic                  mem_write,
  input  logic [31:0]           mem_read_data,
  output logic [31:0]           io_address,
  output logic                  io_memory_read,
  output logic                  io_memory_write,
  output logic [31:0]           io_write_data,
  input  logic [31:0]           io_read_data,
  input  logic                  valid_io_read,
  input  logic                  err_clr,
  output logic                  bus_error,
  output logic [1:0]            err_code,
  output logic [31:0]           err_addr,
  output logic [15:0]           io_access_count
);

  typedef enum logic [1:0] {StIdle, StRdMem, StRdIo, StRdErr} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] io_q, io_d;
  logic        bus_error_q, bus_error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [15:0] count_q, count_d;

  logic       mem_hit, io_hit, misaligned, one_strobe, any_strobe, legal, new_err;
  logic [1:0] new_code;

  // Decode; memory wins if both regions ever overlap.
  always_comb begin
    mem_hit    = (bus.dAddress >= DATA_START_ADDRESS) && (bus.dAddress <= DATA_END_ADDRESS);
    io_hit     = ((bus.dAddress & IO_MASK) == IO_BASE) && !mem_hit;
    misaligned = bus.dAddress[1:0] != 2'b00;
    one_strobe = bus.MemRead ^ bus.MemWrite;
    any_strobe = bus.MemRead | bus.MemWrite;
    legal      = one_strobe && (mem_hit || io_hit) && !misaligned;
    new_err    = any_strobe && !legal;
    if (bus.MemRead && bus.MemWrite) begin
      new_code = 2'd3;
    end else if (misaligned) begin
      new_code = 2'd2;
    end else begin
      new_code = 2'd1;
    end
  end

  // Strobes are forced low while reset is held.
  assign mem_write       = rst && bus.MemWrite && legal && mem_hit;
  assign io_memory_write = rst && bus.MemWrite && legal && io_hit;
  assign io_memory_read  = rst && bus.MemRead  && legal && io_hit;
  assign io_address      = bus.dAddress;
  assign io_write_data   = bus.dWriteData;
  assign bus.dReadData   = rdata_q;
  assign bus_error       = bus_error_q;
  assign err_code        = err_code_q;
  assign err_addr        = err_addr_q;
  assign io_access_count = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A new MemRead is accepted in any state, giving back-to-back reads.
  always_comb begin
    state_d = StIdle;
    if (bus.MemRead) begin
      if (legal && mem_hit) begin
        state_d = StRdMem;
      end else if (legal && io_hit) begin
        state_d = StRdIo;
      end else begin
        state_d = StRdErr;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    unique case (state_q)
      StRdMem: rdata_d = mem_read_data;
      StRdIo:  rdata_d = io_q;
      StRdErr: rdata_d = 32'h0;
      default: rdata_d = rdata_q;
    endcase
  end

  always_comb begin
    io_d = io_q;
    if (bus.MemRead && legal && io_hit) begin
      io_d = valid_io_read ? io_read_data : 32'h0;
    end
  end

  // A coincident clear lets the new error take the freed record.
  always_comb begin
    bus_error_d = bus_error_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      bus_error_d = 1'b0;
      err_code_d  = 2'd0;
      err_addr_d  = 32'h0;
    end
    if (new_err && (!bus_error_q || err_clr)) begin
      bus_error_d = 1'b1;
      err_code_d  = new_code;
      err_addr_d  = bus.dAddress;
    end
  end

  always_comb begin
    count_d = count_q;
    if (io_memory_read || io_memory_write) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q     <= 32'h0;
      io_q        <= 32'h0;
      bus_error_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_addr_q  <= 32'h0;
      count_q     <= 16'h0;
    end else begin
      rdata_q     <= rdata_d;
      io_q        <= io_d;
      bus_error_q <= bus_error_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_dbus_io_bridge.sv
// Self-checking bench for dbus_io_bridge: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_dbus_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_read_data, io_read_data;
  logic        valid_io_read, err_clr;
  logic        mem_write, io_memory_read, io_memory_write, bus_error;
  logic [31:0] io_address, io_write_data, err_addr;
  logic [1:0]  err_code;
  logic [15:0] io_access_count;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  dbus_io_bridge_if bus ();

  dbus_io_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .mem_write       (mem_write),
    .mem_read_data   (mem_read_data),
    .io_address      (io_address),
    .io_memory_read  (io_memory_read),
    .io_memory_write (io_memory_write),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .valid_io_read   (valid_io_read),
    .err_clr         (err_clr),
    .bus_error       (bus_error),
    .err_code        (err_code),
    .err_addr        (err_addr),
    .io_access_count (io_access_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map and access rules.
  function automatic logic in_mem(input logic [31:0] a);
    return (a >= 32'h00002000) && (a <= 32'h00003FFF);
  endfunction

  function automatic logic in_io(input logic [31:0] a);
    return !in_mem(a) && (a[31:8] == 24'h00007F);
  endfunction

  function automatic logic [1:0] err_of(input logic [31:0] a, input logic rd, input logic wr);
    if (!rd && !wr) return 2'd0;
    if (rd && wr) return 2'd3;
    if (a[1:0] != 2'b00) return 2'd2;
    if (!in_mem(a) && !in_io(a)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ok(input logic [31:0] a, input logic rd, input logic wr);
    return (rd || wr) && (err_of(a, rd, wr) == 2'd0);
  endfunction

  // Transaction-level model: a read issued on one edge resolves on the next.
  int          m_pend;  // 0 none, 1 memory, 2 io, 3 error
  logic [31:0] m_rd, m_ioval, m_eaddr;
  logic        m_err;
  logic [1:0]  m_code;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend  <= 0;
      m_rd    <= 32'h0;
      m_ioval <= 32'h0;
      m_err   <= 1'b0;
      m_code  <= 2'd0;
      m_eaddr <= 32'h0;
      m_cnt   <= 16'h0;
    end else begin
      if (m_pend == 1) m_rd <= mem_read_data;
      else if (m_pend == 2) m_rd <= m_ioval;
      else if (m_pend == 3) m_rd <= 32'h0;
      if (bus.MemRead) begin
        if (!ok(bus.dAddress, 1'b1, bus.MemWrite)) m_pend <= 3;
        else if (in_mem(bus.dAddress)) m_pend <= 1;
        else begin
          m_pend  <= 2;
          m_ioval <= valid_io_read ? io_read_data : 32'h0;
        end
      end else begin
        m_pend <= 0;
      end
      if (err_clr) begin
        m_err   <= 1'b0;
        m_code  <= 2'd0;
        m_eaddr <= 32'h0;
      end
      if (err_of(bus.dAddress, bus.MemRead, bus.MemWrite) != 2'd0 && (!m_err || err_clr)) begin
        m_err   <= 1'b1;
        m_code  <= err_of(bus.dAddress, bus.MemRead, bus.MemWrite);
        m_eaddr <= bus.dAddress;
      end
      if (ok(bus.dAddress, bus.MemRead, bus.MemWrite) && in_io(bus.dAddress)) m_cnt <= m_cnt + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dReadData", bus.dReadData, m_rd);
      chk("mem_write", 32'(mem_write),
          32'(rst && bus.MemWrite && ok(bus.dAddress, bus.MemRead, bus.MemWrite)
              && in_mem(bus.dAddress)));
      chk("io_memory_write", 32'(io_memory_write),
          32'(rst && bus.MemWrite && ok(bus.dAddress, bus.MemRead, bus.MemWrite)
              && in_io(bus.dAddress)));
      chk("io_memory_read", 32'(io_memory_read),
          32'(rst && bus.MemRead && ok(bus.dAddress, bus.MemRead, bus.MemWrite)
              && in_io(bus.dAddress)));
      chk("io_address", io_address, bus.dAddress);
      chk("io_write_data", io_write_data, bus.dWriteData);
      chk("bus_error", 32'(bus_error), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("err_addr", err_addr, m_eaddr);
      chk("io_access_count", 32'(io_access_count), 32'(m_cnt));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.dAddress   = a;
    bus.dWriteData = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] edge_addr [8];

  initial begin
    edge_addr = '{32'h00002000, 32'h00003FFC, 32'h00003FFF, 32'h00001FFC,
                  32'h00004000, 32'h00007EFC, 32'h00007FFC, 32'h00008000};
    rst = 1'b0;
    idle();
    mem_read_data = 32'h0;
    io_read_data  = 32'h0;
    valid_io_read = 1'b0;
    err_clr       = 1'b0;
    repeat (2) go();
    rst    = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset dReadData", bus.dReadData, 32'h0);
    chk("reset bus_error", 32'(bus_error), 32'h0);
    chk("reset err_code", 32'(err_code), 32'h0);
    chk("reset count", 32'(io_access_count), 32'h0);

    // Memory read
    go();
    drive(1'b1, 1'b0, 32'h00002004, 32'h0);
    @(negedge clk);
    chk("mem rd no mem_write", 32'(mem_write), 32'h0);
    go();
    idle();
    mem_read_data = 32'hDEADBEEF;
    go();
    mem_read_data = 32'h0;
    @(negedge clk);
    chk("mem rd data", bus.dReadData, 32'hDEADBEEF);
    chk("mem rd no error", 32'(bus_error), 32'h0);

    // I/O write
    go();
    drive(1'b0, 1'b1, 32'h00007F08, 32'h0000A5A5);
    @(negedge clk);
    chk("io wr strobe", 32'(io_memory_write), 32'h1);
    chk("io wr no mem_write", 32'(mem_write), 32'h0);
    chk("io wr data", io_write_data, 32'h0000A5A5);
    go();
    idle();
    @(negedge clk);
    chk("io wr count", 32'(io_access_count), 32'h1);

    // I/O read
    go();
    drive(1'b1, 1'b0, 32'h00007F00, 32'h0);
    valid_io_read = 1'b1;
    io_read_data  = 32'h00001234;
    @(negedge clk);
    chk("io rd strobe", 32'(io_memory_read), 32'h1);
    go();
    idle();
    valid_io_read = 1'b0;
    io_read_data  = 32'h0;
    go();
    @(negedge clk);
    chk("io rd data", bus.dReadData, 32'h00001234);
    chk("io rd count", 32'(io_access_count), 32'h2);

    // Unmapped write then misaligned read
    go();
    drive(1'b0, 1'b1, 32'h00005000, 32'h11111111);
    @(negedge clk);
    chk("unmapped no strobe", 32'({mem_write, io_memory_write, io_memory_read}), 32'h0);
    go();
    drive(1'b1, 1'b0, 32'h00002002, 32'h0);
    @(negedge clk);
    chk("misaligned no strobe", 32'({mem_write, io_memory_write, io_memory_read}), 32'h0);
    go();
    idle();
    @(negedge clk);
    chk("err flag", 32'(bus_error), 32'h1);
    chk("err code unmapped", 32'(err_code), 32'h1);
    chk("err addr", err_addr, 32'h00005000);
    go();
    @(negedge clk);
    chk("err read data", bus.dReadData, 32'h0);
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr flag", 32'(bus_error), 32'h0);
    chk("clr code", 32'(err_code), 32'h0);
    chk("clr addr", err_addr, 32'h0);

    // Read and write together
    go();
    drive(1'b1, 1'b1, 32'h00002000, 32'h0);
    @(negedge clk);
    chk("rw no strobe", 32'({mem_write, io_memory_write, io_memory_read}), 32'h0);
    go();
    idle();
    @(negedge clk);
    chk("rw code", 32'(err_code), 32'h3);
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      int sel, op;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) a = 32'h00002000 + $urandom_range(0, 32'h1FFF);
      else if (sel < 5) a = 32'h00007F00 + $urandom_range(0, 255);
      else if (sel == 5) a = edge_addr[$urandom_range(0, 7)];
      else if (sel == 6) a = $urandom;
      else if (sel < 9) a = (32'h00002000 + $urandom_range(0, 32'h1FFF)) & 32'hFFFFFFFC;
      else a = (32'h00007F00 + $urandom_range(0, 255)) & 32'hFFFFFFFC;
      op = int'($urandom_range(0, 9));
      drive(op < 4 || op == 7, (op >= 4 && op < 8), a, $urandom);
      err_clr       = ($urandom_range(0, 19) == 0);
      valid_io_read = $urandom_range(0, 1) == 1;
      io_read_data  = $urandom;
      mem_read_data = $urandom;
      go();
    end
    idle();
    err_clr = 1'b0;

    // Counter wrap from a fresh reset
    rst = 1'b0;
    go();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h00007F04, 32'h5A5A5A5A);
    repeat (65535) go();
    idle();
    @(negedge clk);
    chk("count at ffff", 32'(io_access_count), 32'h0000FFFF);
    go();
    drive(1'b0, 1'b1, 32'h00007F04, 32'h5A5A5A5A);
    go();
    idle();
    @(negedge clk);
    chk("count wrap", 32'(io_access_count), 32'h0);

    // Reset while an I/O read is in flight
    go();
    drive(1'b1, 1'b0, 32'h00007F10, 32'h0);
    valid_io_read = 1'b1;
    io_read_data  = 32'hCAFEF00D;
    go();
    idle();
    go();
    @(negedge clk);
    chk("pre-reset data", bus.dReadData, 32'hCAFEF00D);
    go();
    drive(1'b1, 1'b0, 32'h00007F14, 32'h0);
    io_read_data = 32'h0BADC0DE;
    go();
    drive(1'b0, 1'b1, 32'h00007F18, 32'h0);
    rst = 1'b0;
    #1;
    chk("mid-read reset data", bus.dReadData, 32'h0);
    chk("reset gates strobe", 32'(io_memory_write), 32'h0);
    #2;
    idle();
    rst = 1'b1;
    go();
    go();
    @(negedge clk);
    chk("read discarded", bus.dReadData, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
